// File: rtl/output_channel_buffer_bank.sv
// Bank of independent per-channel circular FIFOs between the PE writeback stage and the interconnect.
// Optional sticky overflow flag enabled by defining OUTPUT_CHANNEL_OVERFLOW_CHECK_EN.
module output_channel_buffer_bank #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned TAG_WIDTH    = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_CHANNELS-1:0]            write_enable,
    input  logic [WORD_WIDTH-1:0]              write_data,
    input  logic [TAG_WIDTH-1:0]               write_tag,
    output logic [NUM_CHANNELS-1:0]            output_channel_full_status,
    output logic [NUM_CHANNELS-1:0]            output_channel_empty_status,
    output logic [NUM_CHANNELS-1:0]            downstream_valid,
    output logic [NUM_CHANNELS*WORD_WIDTH-1:0] downstream_data,
    output logic [NUM_CHANNELS*TAG_WIDTH-1:0]  downstream_tag,
    input  logic [NUM_CHANNELS-1:0]            downstream_ready,
    output logic                               overflow_error
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic [WORD_WIDTH-1:0] data_q [DEPTH];
        logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
        logic [PTR_W-1:0]      rd_ptr;
        logic [PTR_W-1:0]      wr_ptr;
        logic [CNT_W-1:0]      count;
        logic                  full;
        logic                  empty;
        logic                  push;
        logic                  pop;

        // Status comes only from the registered count.
        assign full  = (count == CNT_W'(DEPTH));
        assign empty = (count == '0);
        // A full channel rejects writes even when it dequeues in the same cycle.
        assign push  = write_enable[i] && !full;
        assign pop   = !empty && downstream_ready[i];

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end

        // Payload storage needs no reset; valid gates it.
        always_ff @(posedge clk) begin
            if (push) begin
                data_q[wr_ptr] <= write_data;
                tag_q[wr_ptr]  <= write_tag;
            end
        end

        assign output_channel_full_status[i]  = full;
        assign output_channel_empty_status[i] = empty;
        assign downstream_valid[i]            = !empty;
        assign downstream_data[i*WORD_WIDTH +: WORD_WIDTH] = data_q[rd_ptr];
        assign downstream_tag[i*TAG_WIDTH +: TAG_WIDTH]    = tag_q[rd_ptr];
    end

`ifdef OUTPUT_CHANNEL_OVERFLOW_CHECK_EN
    logic overflow_q;

    // Sticky until reset once any selected channel was full at a write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (|(write_enable & output_channel_full_status)) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_error = overflow_q;
`else
    assign overflow_error = 1'b0;
`endif

endmodule

// File: doc/output_channel_buffer_bank.md
OUTPUT_CHANNEL_BUFFER_BANK -- requirements
Module: output_channel_buffer_bank

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of PE output channels.
REQ-002 SHALL have parameter DEPTH, default 2, FIFO entries per channel; legal values are powers of two, 2..16.
REQ-003 SHALL have parameter WORD_WIDTH, default 32, data word width.
REQ-004 SHALL have parameter TAG_WIDTH, default 2, tag width.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have port write_enable  input  NUM_CHANNELS  one-hot or zero channel-write request from the PE writeback stage.
REQ-008 SHALL have port write_data  input  WORD_WIDTH  word to enqueue.
REQ-009 SHALL have port write_tag  input  TAG_WIDTH  tag to enqueue.
REQ-010 SHALL have port output_channel_full_status  output  NUM_CHANNELS  bit i high when channel i holds DEPTH entries.
REQ-011 SHALL have port output_channel_empty_status  output  NUM_CHANNELS  bit i high when channel i holds 0 entries.
REQ-012 SHALL have port downstream_valid  output  NUM_CHANNELS  per-channel head entry present.
REQ-013 SHALL have port downstream_data  output  NUM_CHANNELS*WORD_WIDTH  per-channel head word; channel i at bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-014 SHALL have port downstream_tag  output  NUM_CHANNELS*TAG_WIDTH  per-channel head tag, packed like downstream_data.
REQ-015 SHALL have port downstream_ready  input  NUM_CHANNELS  per-channel interconnect accept.
REQ-016 SHALL have port overflow_error  output  1  sticky flag for a write to a full channel.

Function
REQ-017 SHALL implement one independent circular FIFO per channel, with read pointer, write pointer and count register of width clog2(DEPTH)+1.
REQ-018 SHALL enqueue write_data/write_tag into channel i at the clock edge when write_enable[i]=1 and the channel is not full; the entry is visible on downstream outputs the next cycle (1-cycle latency).
REQ-019 SHALL derive downstream_valid[i] as count_i != 0 and present the head entry combinationally from storage; no output bypass of the incoming write.
REQ-020 SHALL dequeue channel i at the edge when downstream_valid[i] && downstream_ready[i], advancing the read pointer.
REQ-021 SHALL hold head data and tag stable while valid && !ready; valid SHALL NOT drop without a completed handshake.
REQ-022 SHALL derive full_status[i] = (count_i == DEPTH) and empty_status[i] = (count_i == 0) from registered count only, with no combinational path from write_enable or downstream_ready.
REQ-023 SHALL, on simultaneous enqueue and dequeue on a non-full channel, leave count unchanged and advance both pointers.
REQ-024 SHALL reject a write to a full channel even if the same channel dequeues in that cycle; the upstream pessimistic full tracking guarantees no such write.
REQ-025 SHALL wrap pointers modulo DEPTH, with no bubble at wrap-around.
REQ-026 SHALL, if write_enable has more than one bit set, enqueue into every selected non-full channel (broadcast).

Reset
REQ-027 SHALL, when reset_n=0 at a clock edge, clear all pointers and counts, discard in-flight entries and clear overflow_error.
REQ-028 SHALL, after reset, drive full_status=0, empty_status=all ones and downstream_valid=0; data/tag outputs are don't-care while valid=0.
REQ-029 SHALL give reset priority over simultaneous writes and handshakes in the same cycle.

Configuration
REQ-030 SHALL, with OUTPUT_CHANNEL_OVERFLOW_CHECK_EN defined, set overflow_error on a rejected write to a full channel and hold it until reset.
REQ-031 SHALL, without OUTPUT_CHANNEL_OVERFLOW_CHECK_EN, tie overflow_error to 0, still drop the rejected write silently, and leave the port list unchanged.

Verification
REQ-032 SHALL cover: reset, then write 0xA5 tag 1 to ch0 -> next cycle valid[0]=1, data=0xA5, tag=1, empty[0]=0.
REQ-033 SHALL cover: DEPTH=2, two writes to ch1 with ready=0 -> full[1]=1 after the 2nd edge; a 3rd write is dropped and overflow_error=1 (macro on) or 0 (macro off).
REQ-034 SHALL cover: ch2 holding 1 entry, simultaneous write and ready -> count stays 1 and FIFO order is preserved.
REQ-035 SHALL cover: ch3 full with ready=1 plus a write in the same cycle -> the write is rejected and count goes to DEPTH-1.
REQ-036 SHALL cover: stream 20 words through ch0 with random ready stalls -> in-order delivery, correct pointer wrap, data stable during stalls.
REQ-037 SHALL cover: reset_n=0 asserted with all channels full -> next cycle all valid=0, full=0, overflow_error=0.
